mmc_lcm_stage: RTL and testbench



---
 rtl/mmc_lcm_stage.sv | 154 +++++++++++++++
 tb/tb_mmc_lcm_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_lcm_stage.sv
// LCM stage behind the mdc GCD datapath: LCM = (x*y)/gcd using a shift-add multiplier
// followed by a restoring divider, with valid/ready handshakes on both sides.
module mmc_lcm_stage #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               enb_i,
   input  logic [WIDTH-1:0]   dtx_in,
   input  logic [WIDTH-1:0]   dty_in,
   input  logic [WIDTH-1:0]   mdc_in,
   input  logic               vld_i,
   output logic               rdy_o,
   output logic [2*WIDTH-1:0] dt_o,
   output logic               err_o,
   output logic               vld_o,
   input  logic               rdy_i
);

   localparam int unsigned CW = $clog2(2 * WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(2 * WIDTH - 1);

   logic [1:0]         state_q, state_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   gcd_q, gcd_d;
   // Holds the product during MUL, then shifts into the quotient during DIV.
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] dt_q, dt_d;
   logic               err_q, err_d;
   logic               vld_q, vld_d;

   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_sub;
   logic               div_ge;
   logic [2*WIDTH-1:0] quo_next;

   assign div_shift = {rem_q[WIDTH-1:0], prod_q[2*WIDTH-1]};
   assign div_sub   = div_shift - {1'b0, gcd_q};
   assign div_ge    = rem_q[WIDTH] | (div_shift >= {1'b0, gcd_q});
   assign quo_next  = {prod_q[2*WIDTH-2:0], div_ge};

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      gcd_d    = gcd_q;
      prod_d   = prod_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      dt_d     = dt_q;
      err_d    = err_q;
      vld_d    = vld_q;
      if (enb_i) begin
         case (state_q)
            ST_IDLE: begin
               if (vld_i) begin
                  mcand_d  = {{WIDTH{1'b0}}, dtx_in};
                  mplier_d = dty_in;
                  gcd_d    = mdc_in;
                  prod_d   = '0;
                  rem_d    = '0;
                  cnt_d    = '0;
                  if (dtx_in == '0 || dty_in == '0) begin
                     dt_d    = '0;
                     err_d   = 1'b0;
                     vld_d   = 1'b1;
                     state_d = ST_DONE;
                  end else if (mdc_in == '0) begin
                     dt_d    = '0;
                     err_d   = 1'b1;
                     vld_d   = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
               mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
               mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
               if (cnt_q == MUL_LAST) begin
                  cnt_d   = '0;
                  rem_d   = '0;
                  state_d = ST_DIV;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_DIV: begin
               rem_d  = div_ge ? div_sub : div_shift;
               prod_d = quo_next;
               if (cnt_q == DIV_LAST) begin
                  cnt_d   = '0;
                  dt_d    = quo_next;
                  err_d   = (rem_d != '0);
                  vld_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               if (rdy_i) begin
                  vld_d   = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         gcd_q    <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         dt_q     <= '0;
         err_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         gcd_q    <= gcd_d;
         prod_q   <= prod_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         dt_q     <= dt_d;
         err_q    <= err_d;
         vld_q    <= vld_d;
      end
   end

   assign rdy_o = (state_q == ST_IDLE);
   assign dt_o  = dt_q;
   assign err_o = err_q;
   assign vld_o = vld_q;

endmodule

// File: tb/tb_mmc_lcm_stage.sv
// Directed bench for mmc_lcm_stage; latencies are counted in rising edges after the transfer edge.
module tb_mmc_lcm_stage;

   localparam int W = 8;

   logic           clk_i = 1'b0;
   logic           rstn_i = 1'b0;
   logic           enb_i = 1'b1;
   logic [W-1:0]   dtx_in = '0;
   logic [W-1:0]   dty_in = '0;
   logic [W-1:0]   mdc_in = '0;
   logic           vld_i = 1'b0;
   logic           rdy_o;
   logic [2*W-1:0] dt_o;
   logic           err_o;
   logic           vld_o;
   logic           rdy_i = 1'b0;

   int checks = 0;
   int failures = 0;

   mmc_lcm_stage #(.WIDTH(W)) dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .enb_i  (enb_i),
      .dtx_in (dtx_in),
      .dty_in (dty_in),
      .mdc_in (mdc_in),
      .vld_i  (vld_i),
      .rdy_o  (rdy_o),
      .dt_o   (dt_o),
      .err_o  (err_o),
      .vld_o  (vld_o),
      .rdy_i  (rdy_i)
   );

   always #5 clk_i = ~clk_i;

   // Transfer one triple; returns 1 ns after the transfer edge.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] g);
      dtx_in = x;
      dty_in = y;
      mdc_in = g;
      vld_i  = 1'b1;
      @(posedge clk_i);
      #1 vld_i = 1'b0;
   endtask

   // Counts edges until vld_o is seen; a value of 200 means it never came.
   task automatic wait_vld(output int lat);
      lat = 0;
      while (!vld_o && lat < 200) begin
         @(posedge clk_i);
         #1 lat++;
      end
   endtask

   task automatic consume();
      rdy_i = 1'b1;
      @(posedge clk_i);
      #1 rdy_i = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (dt_o !== 16'd0 || err_o !== 1'b0 || vld_o !== 1'b0 || rdy_o !== 1'b1) begin
         failures++;
         $display("FAIL reset: dt=%0d err=%b vld=%b rdy=%b, want 0 0 0 1", dt_o, err_o, vld_o, rdy_o);
      end
      @(posedge clk_i);
      #1 rstn_i = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      send(8'd12, 8'd18, 8'd6);
      checks++;
      if (rdy_o !== 1'b0) begin
         failures++;
         $display("FAIL basic_rdy_busy: rdy=%b want 0", rdy_o);
      end
      wait_vld(lat);
      checks++;
      if (lat != 24) begin
         failures++;
         $display("FAIL basic_latency: got %0d edges want 24", lat);
      end
      checks++;
      if (dt_o !== 16'd36 || err_o !== 1'b0 || rdy_o !== 1'b0) begin
         failures++;
         $display("FAIL basic_result: dt=%0d err=%b rdy=%b want 36 0 0", dt_o, err_o, rdy_o);
      end
      consume();
      checks++;
      if (vld_o !== 1'b0 || rdy_o !== 1'b1 || dt_o !== 16'd36) begin
         failures++;
         $display("FAIL basic_release: vld=%b rdy=%b dt=%0d want 0 1 36", vld_o, rdy_o, dt_o);
      end
   endtask

   task automatic test_max();
      int lat;
      send(8'd255, 8'd254, 8'd1);
      wait_vld(lat);
      checks++;
      if (lat != 24 || dt_o !== 16'hFD02 || err_o !== 1'b0) begin
         failures++;
         $display("FAIL max_range: lat=%0d dt=%h err=%b want 24 fd02 0", lat, dt_o, err_o);
      end
      consume();
   endtask

   task automatic test_fast_path();
      int lat;
      send(8'd0, 8'd7, 8'd7);
      wait_vld(lat);
      checks++;
      if (lat != 0 || dt_o !== 16'd0 || err_o !== 1'b0) begin
         failures++;
         $display("FAIL zero_operand: lat=%0d dt=%0d err=%b want 0 0 0", lat, dt_o, err_o);
      end
      consume();
      send(8'd6, 8'd4, 8'd0);
      wait_vld(lat);
      checks++;
      if (lat != 0 || dt_o !== 16'd0 || err_o !== 1'b1) begin
         failures++;
         $display("FAIL zero_gcd: lat=%0d dt=%0d err=%b want 0 0 1", lat, dt_o, err_o);
      end
      consume();
   endtask

   task automatic test_bad_gcd();
      int lat;
      send(8'd6, 8'd4, 8'd5);
      wait_vld(lat);
      checks++;
      if (lat != 24 || dt_o !== 16'd4 || err_o !== 1'b1) begin
         failures++;
         $display("FAIL bad_gcd: lat=%0d dt=%0d err=%b want 24 4 1", lat, dt_o, err_o);
      end
      consume();
   endtask

   task automatic test_stall();
      int lat;
      send(8'd12, 8'd18, 8'd6);
      repeat (12) @(posedge clk_i);
      #1 enb_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if (vld_o !== 1'b0 || rdy_o !== 1'b0) begin
         failures++;
         $display("FAIL stall_hold: vld=%b rdy=%b want 0 0", vld_o, rdy_o);
      end
      enb_i = 1'b1;
      wait_vld(lat);
      checks++;
      if (lat + 15 != 27 || dt_o !== 16'd36 || err_o !== 1'b0) begin
         failures++;
         $display("FAIL stall_latency: lat=%0d dt=%0d err=%b want 27 36 0", lat + 15, dt_o, err_o);
      end
      // Disabled stage must not complete the output handshake.
      enb_i = 1'b0;
      rdy_i = 1'b1;
      @(posedge clk_i);
      #1;
      rdy_i = 1'b0;
      enb_i = 1'b1;
      checks++;
      if (vld_o !== 1'b1 || rdy_o !== 1'b0) begin
         failures++;
         $display("FAIL stall_no_handshake: vld=%b rdy=%b want 1 0", vld_o, rdy_o);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      int lat;
      int held_bad;
      send(8'd12, 8'd18, 8'd6);
      wait_vld(lat);
      // Upstream presents the next triple while the result is still pending.
      dtx_in = 8'd5;
      dty_in = 8'd3;
      mdc_in = 8'd1;
      vld_i  = 1'b1;
      held_bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i);
         #1;
         if (vld_o !== 1'b1 || dt_o !== 16'd36 || rdy_o !== 1'b0) held_bad++;
      end
      checks++;
      if (held_bad != 0) begin
         failures++;
         $display("FAIL backpressure_hold: %0d bad cycles, last vld=%b dt=%0d want 1 36",
                  held_bad, vld_o, dt_o);
      end
      rdy_i = 1'b1;
      @(posedge clk_i);
      #1 rdy_i = 1'b0;
      checks++;
      if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin
         failures++;
         $display("FAIL handshake_release: vld=%b rdy=%b want 0 1", vld_o, rdy_o);
      end
      @(posedge clk_i);
      #1 vld_i = 1'b0;
      checks++;
      if (rdy_o !== 1'b0) begin
         failures++;
         $display("FAIL next_accept: rdy=%b want 0", rdy_o);
      end
      wait_vld(lat);
      checks++;
      if (lat != 24 || dt_o !== 16'd15 || err_o !== 1'b0) begin
         failures++;
         $display("FAIL next_result: lat=%0d dt=%0d err=%b want 24 15 0", lat, dt_o, err_o);
      end
      consume();
   endtask

   task automatic test_reset_mid_div();
      int lat;
      send(8'd12, 8'd18, 8'd6);
      repeat (15) @(posedge clk_i);
      #2 rstn_i = 1'b0;
      #1;
      checks++;
      if (dt_o !== 16'd0 || err_o !== 1'b0 || vld_o !== 1'b0 || rdy_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_div: dt=%0d err=%b vld=%b rdy=%b want 0 0 0 1",
                  dt_o, err_o, vld_o, rdy_o);
      end
      @(posedge clk_i);
      #1 rstn_i = 1'b1;
      send(8'd8, 8'd12, 8'd4);
      wait_vld(lat);
      checks++;
      if (lat != 24 || dt_o !== 16'd24 || err_o !== 1'b0) begin
         failures++;
         $display("FAIL after_reset: lat=%0d dt=%0d err=%b want 24 24 0", lat, dt_o, err_o);
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_fast_path();
      test_bad_gcd();
      test_stall();
      test_back_to_back();
      test_reset_mid_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
